// File: rtl/synth_seq_pkg.sv
// Shared types for the synth step sequencer.
// Holds the FSM states, the period floor and the pattern entry layout.
package synth_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MIN_PERIOD = 2;
  localparam int NOTE_W     = 12;

  typedef struct packed {
    logic              on;
    logic [NOTE_W-1:0] note;
  } step_t;

endpackage

// File: rtl/seq_pattern_ram.sv
// Pattern store for the step sequencer.
// Register array with async clear, sync write and combinational read.
module seq_pattern_ram
  import synth_seq_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int OSC_W = 12,
  localparam int AW = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [OSC_W:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [OSC_W:0] rd_data
);

  logic [OSC_W:0] mem_q [STEPS];
  logic [OSC_W:0] mem_d [STEPS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read sees pre-edge content, so a same-edge write is not visible to a load.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/synth_sequencer.sv
// Step sequencer feeding the synth voice.
// Plays a stored note pattern at a programmable tempo with a gated trig.
module synth_sequencer
  import synth_seq_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int OSC_W = 12,
  parameter int PER_W = 24,
  localparam int AW = $clog2(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [PER_W-1:0] step_period,
  input  logic [PER_W-1:0] gate_len,
  input  logic [AW-1:0]    length,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [OSC_W-1:0] wr_note,
  input  logic             wr_on,
  output logic             trig,
  output logic [OSC_W-1:0] osc_count,
  output logic [AW-1:0]    step_idx,
  output logic             step_strobe
);

  state_e           state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             trig_q, trig_d;
  logic [OSC_W-1:0] osc_q, osc_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             strobe_q, strobe_d;

  logic [PER_W-1:0] per_m1;
  logic [PER_W-1:0] cnt_inc;
  logic [AW-1:0]    idx_inc;
  logic [AW-1:0]    nxt_idx;
  logic [AW-1:0]    rd_addr;
  logic [OSC_W:0]   rd_data;
  logic             rd_on;
  logic [OSC_W-1:0] rd_note;
  logic             load;

  seq_pattern_ram #(
    .STEPS(STEPS),
    .OSC_W(OSC_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data({wr_on, wr_note}),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign rd_on   = rd_data[OSC_W];
  assign rd_note = rd_data[OSC_W-1:0];

  always_comb begin
    per_m1 = step_period - 1'b1;
    if (step_period < PER_W'(MIN_PERIOD)) per_m1 = PER_W'(MIN_PERIOD - 1);
    cnt_inc = cnt_q + 1'b1;
    idx_inc = idx_q + 1'b1;
    nxt_idx = (idx_q >= length) ? '0 : idx_inc;
    rd_addr = (state_q == RUN) ? nxt_idx : '0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trig_d   = trig_q;
    osc_d    = osc_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d  = RUN;
          idx_d    = '0;
          cnt_d    = '0;
          strobe_d = 1'b1;
          load     = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          trig_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == gate_len) trig_d = 1'b0;
          if (cnt_q == per_m1) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
            idx_d    = nxt_idx;
            load     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Rests keep the old pitch so the release tail does not jump.
    if (load) begin
      if (rd_on) begin
        osc_d  = rd_note;
        trig_d = (gate_len != '0);
      end else begin
        trig_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      trig_q   <= 1'b0;
      osc_q    <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      osc_q    <= osc_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
    end
  end

  assign trig        = trig_q;
  assign osc_count   = osc_q;
  assign step_idx    = idx_q;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_synth_sequencer.sv
// Self-checking bench for synth_sequencer.
// Directed test-plan scenarios plus random play against a step-level model.
module tb_synth_sequencer;
  import synth_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        run;
  logic [23:0] step_period;
  logic [23:0] gate_len;
  logic [3:0]  length;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [11:0] wr_note;
  logic        wr_on;
  logic        trig;
  logic [11:0] osc_count;
  logic [3:0]  step_idx;
  logic        step_strobe;

  synth_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step_period(step_period),
    .gate_len   (gate_len),
    .length     (length),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_note    (wr_note),
    .wr_on      (wr_on),
    .trig       (trig),
    .osc_count  (osc_count),
    .step_idx   (step_idx),
    .step_strobe(step_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int trig_seen;
  int strobe_seen;

  step_t       pat [16];
  bit          m_play;
  int          m_idx;
  int          m_age;
  bit          m_on;
  logic [11:0] m_note;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) pat[i] = '0;
    m_play = 0;
    m_idx  = 0;
    m_age  = 0;
    m_on   = 0;
    m_note = '0;
  endtask

  task automatic m_load(input int i);
    m_on = pat[i].on;
    if (pat[i].on) m_note = pat[i].note;
  endtask

  task automatic m_edge();
    int p;
    p = (step_period < 2) ? 2 : int'(step_period);
    if (!m_play) begin
      if (run) begin
        m_play = 1;
        m_idx  = 0;
        m_age  = 0;
        m_load(0);
      end
    end else if (!run) begin
      m_play = 0;
      m_idx  = 0;
      m_age  = 0;
    end else begin
      m_age++;
      if (m_age == p) begin
        m_age = 0;
        m_idx = (m_idx >= int'(length)) ? 0 : m_idx + 1;
        m_load(m_idx);
      end
    end
    if (wr_en) pat[wr_addr] = {wr_on, wr_note};
  endtask

  task automatic m_compare();
    bit et;
    et = m_play && m_on && (m_age < int'(gate_len));
    chk("trig", 32'(trig), 32'(et));
    chk("osc", 32'(osc_count), 32'(m_note));
    chk("idx", 32'(step_idx), 32'(m_play ? m_idx : 0));
    chk("strobe", 32'(step_strobe), 32'(m_play && m_age == 0));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      m_edge();
      #1;
      m_compare();
      trig_seen   += int'(trig);
      strobe_seen += int'(step_strobe);
    end
  endtask

  task automatic wr(input int a, input bit on, input int note);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_on   = on;
    wr_note = 12'(note);
    cyc(1);
    wr_en   = 1'b0;
  endtask

  task automatic prog_common();
    wr(0, 1, 66);
    wr(1, 1, 100);
    wr(2, 0, 0);
    wr(3, 1, 200);
  endtask

  task automatic stop();
    run = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    step_period = 24'd10;
    gate_len = 24'd4;
    length = 4'd3;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_note = '0;
    wr_on = 1'b0;
    m_reset();
    #3;
    chk("rst_trig", 32'(trig), 0);
    chk("rst_osc", 32'(osc_count), 0);
    chk("rst_idx", 32'(step_idx), 0);
    chk("rst_strobe", 32'(step_strobe), 0);
    #9 rst = 1'b0;

    // empty pattern: strobes at tempo, never a trig
    run = 1'b1;
    trig_seen = 0;
    strobe_seen = 0;
    cyc(40);
    chk("empty_strobes", 32'(strobe_seen), 4);
    chk("empty_trig", 32'(trig_seen), 0);
    stop();

    // basic play
    prog_common();
    run = 1'b1;
    trig_seen = 0;
    cyc(1);
    chk("b0_osc", 32'(osc_count), 66);
    chk("b0_trig", 32'(trig), 1);
    cyc(10);
    chk("b1_osc", 32'(osc_count), 100);
    chk("b1_idx", 32'(step_idx), 1);
    cyc(10);
    chk("b2_trig", 32'(trig), 0);
    chk("b2_osc", 32'(osc_count), 100);
    cyc(10);
    chk("b3_osc", 32'(osc_count), 200);
    cyc(10);
    chk("bw_idx", 32'(step_idx), 0);
    chk("bw_osc", 32'(osc_count), 66);
    chk("bw_strobe", 32'(step_strobe), 1);
    chk("b_trigcnt", 32'(trig_seen), 13);
    stop();

    // legato
    gate_len = 24'd10;
    run = 1'b1;
    cyc(1);
    trig_seen = 0;
    cyc(19);
    chk("leg_hold", 32'(trig_seen), 19);
    chk("leg_osc", 32'(osc_count), 100);
    cyc(1);
    chk("leg_rest", 32'(trig), 0);
    cyc(10);
    chk("leg_s3", 32'(trig), 1);
    stop();

    // stop and restart
    gate_len = 24'd4;
    run = 1'b1;
    cyc(13);
    run = 1'b0;
    cyc(1);
    chk("stop_trig", 32'(trig), 0);
    chk("stop_idx", 32'(step_idx), 0);
    chk("stop_osc", 32'(osc_count), 100);
    run = 1'b1;
    cyc(1);
    chk("rs_osc", 32'(osc_count), 66);
    chk("rs_strobe", 32'(step_strobe), 1);

    // async reset while the gate is open
    chk("pre_rst_trig", 32'(trig), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_trig", 32'(trig), 0);
    chk("arst_osc", 32'(osc_count), 0);
    chk("arst_idx", 32'(step_idx), 0);
    m_reset();
    #1 rst = 1'b0;
    trig_seen = 0;
    cyc(25);
    chk("arst_notrig", 32'(trig_seen), 0);
    stop();

    // length cut while on step 3
    prog_common();
    run = 1'b1;
    cyc(33);
    chk("len_at3", 32'(step_idx), 3);
    length = 4'd1;
    cyc(8);
    chk("len_wrap", 32'(step_idx), 0);
    cyc(10);
    chk("len_s1", 32'(step_idx), 1);
    cyc(10);
    chk("len_s0", 32'(step_idx), 0);
    stop();
    length = 4'd3;

    // zero period acts as two
    step_period = 24'd0;
    run = 1'b1;
    cyc(1);
    strobe_seen = 0;
    cyc(20);
    chk("per0_strobes", 32'(strobe_seen), 10);
    stop();
    step_period = 24'd10;

    // zero gate never triggers
    gate_len = 24'd0;
    run = 1'b1;
    trig_seen = 0;
    cyc(40);
    chk("gate0", 32'(trig_seen), 0);
    stop();
    gate_len = 24'd4;

    // write colliding with the load of step 1
    run = 1'b1;
    cyc(10);
    wr_en = 1'b1;
    wr_addr = 4'd1;
    wr_on = 1'b1;
    wr_note = 12'd150;
    cyc(1);
    wr_en = 1'b0;
    chk("rbw_old", 32'(osc_count), 100);
    cyc(40);
    chk("rbw_new", 32'(osc_count), 150);
    stop();

    // random play
    for (int c = 0; c < 4000; c++) begin
      if (!m_play && !run) begin
        step_period = 24'($urandom_range(0, 12));
        gate_len = 24'($urandom_range(0, 14));
        length = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 99) < 2) run = ~run;
      if ($urandom_range(0, 99) < 1) length = 4'($urandom_range(0, 15));
      wr_en = ($urandom_range(0, 99) < 15);
      wr_addr = 4'($urandom_range(0, 15));
      wr_on = 1'($urandom_range(0, 1));
      wr_note = 12'($urandom_range(0, 4095));
      cyc(1);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/synth_sequencer.md
Name: synth_sequencer

Overview:
Step sequencer that drives the existing synth voice.
- Holds a programmable pattern of up to STEPS notes and steps through it at a programmable tempo.
- Each step starts with a one-cycle strobe and outputs the step's oscillator half-period (synth osc_count) plus a gated trig that fires the synth ADSR.
- Sits directly upstream of synth; the ADSR and filter settings stay static, configured by the top level.

Parameters:
STEPS, 16, pattern length in steps (power of 2, ≥2); AW = log2(STEPS)
OSC_W, 12, width of note value (synth osc_count)
PER_W, 24, width of step period and gate length counters

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
run  in  1  level; 1 = play, 0 = stop
step_period  in  PER_W  clock cycles per step; values <2 treated as 2
gate_len  in  PER_W  cycles trig is held high from step start; 0 = never trigger
length  in  AW  index of last played step (steps played = length+1)
wr_en  in  1  pattern write strobe
wr_addr  in  AW  pattern write address
wr_note  in  OSC_W  note value written
wr_on  in  1  1 = note step, 0 = rest
trig  out  1  gate to synth trig
osc_count  out  OSC_W  note value to synth osc_count
step_idx  out  AW  index of the step currently playing
step_strobe  out  1  one-cycle pulse in the first cycle of each step

Behaviour:
Reset (async):
- state=IDLE; trig, osc_count, step_idx, step_strobe = 0; internal cycle counter cnt = 0.
- All pattern entries cleared to {on=0, note=0}.

Pattern write:
- Synchronous: entry[wr_addr] <= {wr_on, wr_note} when wr_en.
- Allowed in any state.
- Read-before-write: a step loaded in the same edge as a write to its address uses the old content.

Registered outputs:
- All outputs are registered; they are never combinational from inputs.

States IDLE, RUN:
- IDLE, run=1 at edge:
  - state<=RUN, step_idx<=0, cnt<=0, step_strobe<=1.
  - Load step 0: if on, osc_count<=note and trig<=(gate_len!=0); if rest, osc_count holds and trig<=0.
- RUN, run=1, each edge:
  - step_strobe<=0 by default.
  - cnt<=cnt+1.
  - If cnt+1==gate_len, trig<=0.
- RUN step boundary (cnt==P-1, P=max(step_period,2)):
  - cnt<=0, step_strobe<=1.
  - step_idx <= (step_idx>=length) ? 0 : step_idx+1.
  - Load the next step as above.
  - Boundary load takes priority over the gate-off compare.
- Legato: when gate_len≥P and the next step is on, trig stays 1 across the boundary with no low cycle, so the ADSR does not retrigger. Only osc_count changes.
- Retrigger: when gate_len<P, trig is low for P-gate_len cycles between consecutive on-steps.
- Rest step: trig<=0 at its start; osc_count holds the previous value so the release tail keeps its pitch.
- RUN, run=0 at edge (takes priority over the boundary):
  - state<=IDLE, trig<=0, step_strobe<=0, step_idx<=0, cnt<=0.
  - osc_count holds.

Live inputs:
- step_period, gate_len and length are sampled every cycle; changes take effect immediately.
- length reduced below step_idx: wraps to 0 at the next boundary (the ≥ compare).
- step_period reduced below cnt+1: the boundary fires when cnt reaches PER_W all-ones wrap. That is a misuse case and is tolerated; the bench must not depend on it.
- Recommended use: change step_period only at step_strobe.

Decomposition:
- Package synth_seq_pkg: state enum (IDLE, RUN), MIN_PERIOD=2, step entry struct {on, note}.
- Sub-module seq_pattern_ram:
  - STEPS×(1+OSC_W) register array with async clear.
  - Synchronous write port; combinational read port addressed by the next-step index.
- Remaining logic (FSM, cnt, output registers) lives in synth_sequencer.

Test Plan:
Common setup: pattern {0:on,66; 1:on,100; 2:rest,0; 3:on,200}, length=3, step_period=10, gate_len=4.
1. Reset: assert rst with no clock -> all outputs 0 immediately. Then run=1 with an empty pattern -> step_strobe every 10 cycles, trig never 1.
2. Basic play, common setup, run=1 -> step_strobe every 10 cycles; osc_count 66,100,100,200,66…; trig high 4 cycles at steps 0,1,3, low at step 2; step_idx wraps 3->0 at cycle 40.
3. Legato: gate_len=10 -> trig 1 continuously through steps 0–1 (osc_count 66->100 while trig stays 1); trig 0 at step 2 start; rises again at step 3.
4. Stop/restart: run=0 at cnt=2 of step 1 -> next edge trig=0, step_idx=0, osc_count=100 held. run=1 -> step 0 reloads, osc_count=66, strobe=1.
5. Async reset mid-gate: rst pulsed between clock edges while trig=1 -> trig=0 without a clock edge; pattern cleared (subsequent run gives no trig).
6. Edge cases:
   - length 3->1 while at step 3 -> next step is 0.
   - step_period=0 -> behaves as 2.
   - gate_len=0 -> no trig.
   - Write to address 1 in the same edge step 1 loads -> old note 100 played, new value played on the next pass.
